param_cpu_core: RTL
===================

Name: param_cpu_core

Overview:
Parametrised successor to the team's 8-bit single-cycle processor. It is a multi-cycle core with configurable data width, register count and PC width. It fetches 32-bit instructions over a valid/request handshake, which allows instruction memory wait states. It adds subtract, jump and branch-if-equal, clears the register file on reset, and flags illegal opcodes.

Parameters:
DATA_W, 8, datapath and register width in bits; must be >= 8.
REG_CNT, 8, number of general registers; power of two, 2..256.
PC_W, 32, program counter width; PC arithmetic wraps mod 2^PC_W.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  synchronous active-low reset; sampled on the CLK rising edge.
INSTR_REQ  out  1  fetch request; high while the core waits for an instruction.
PC  out  PC_W  byte address of the instruction being fetched or executed.
INSTRUCTION  in  32  instruction word; sampled only when INSTR_REQ and INSTR_VALID are both high.
INSTR_VALID  in  1  instruction memory response valid.
ALU_OUT  out  DATA_W  registered result of the last ALU operation.
ZERO  out  1  registered flag; 1 when that result is all zeros.
RETIRE  out  1  one-cycle pulse per completed instruction, including illegal ones.
ILLEGAL_OP  out  1  one-cycle pulse coincident with RETIRE for an undefined opcode.

Behaviour:
- Instruction fields:
  - opcode = [31:24]
  - rd / branch offset = [23:16]
  - rs1 = [15:8]
  - rs2 / imm = [7:0]
  - Register indices use the low log2(REG_CNT) bits of their field.
- Opcodes:
  - 0x00 loadi: rd = zext(imm)
  - 0x01 mov: rd = R[rs2]
  - 0x02 add: rd = R[rs1] + R[rs2]
  - 0x03 sub: rd = R[rs1] + ~R[rs2] + 1
  - 0x04 and: rd = R[rs1] & R[rs2]
  - 0x05 or: rd = R[rs1] | R[rs2]
  - 0x06 j: no register write
  - 0x07 beq: computes R[rs1] - R[rs2], no register write
  - All other opcodes are illegal.
- Arithmetic: all results are modulo 2^DATA_W; no carry or overflow output.
- Reset (RESET == 0 at an edge):
  - PC = 0, INSTR_REQ = 0, ALU_OUT = 0, ZERO = 1, RETIRE = 0, ILLEGAL_OP = 0.
  - All REG_CNT registers = 0; FSM goes to RST.
  - Reset overrides any in-flight fetch or execute. No register write or PC update from the aborted instruction.
- FSM has three states:
  - RST: entered while RESET is low. On the first edge with RESET high, go to FETCH and set INSTR_REQ = 1.
  - FETCH: INSTR_REQ = 1, PC held stable. On an edge where INSTR_VALID = 1, latch INSTRUCTION into the internal IR, drop INSTR_REQ and go to EXEC. While INSTR_VALID = 0, remain in FETCH indefinitely with no state change.
  - EXEC: exactly one cycle. The register file is read combinationally from IR. On the closing edge:
    - Write rd when the opcode is a writer.
    - Update ALU_OUT and ZERO for opcodes 0x00-0x05 and 0x07; j and illegal opcodes leave both unchanged.
    - Update PC.
    - Pulse RETIRE (and ILLEGAL_OP if applicable).
    - Raise INSTR_REQ and return to FETCH.
- Next-PC rule:
  - Default: PC + 4.
  - j: PC + 4 + sext(off8) * 4.
  - beq: the same jump target if R[rs1] == R[rs2], else PC + 4.
  - Offset is signed 8-bit, in instruction words.
- Timing: minimum 2 cycles per instruction (1 FETCH with immediate valid, plus EXEC). RETIRE is high in the cycle after EXEC.
- Hazards: a write to rd becomes visible to the next instruction's EXEC. rd may equal rs1 or rs2; reads use pre-write values.
- Illegal opcode: no register write, ALU_OUT and ZERO unchanged, PC + 4.
- Signal stability: INSTRUCTION and INSTR_VALID are ignored outside FETCH. PC never changes while INSTR_REQ = 1.

Test Plan:
1. Hold RESET low 3 cycles, release, return INSTR_VALID immediately. Execute loadi r1,5; loadi r2,3; add r3,r1,r2 -> ALU_OUT = 8, ZERO = 0, PC = 0x0C after the third retire, RETIRE pulses every 2 cycles.
2. sub r4,r2,r2 -> ALU_OUT = 0, ZERO = 1, r4 = 0. Then sub r5,r2,r1 -> ALU_OUT = 0xFE (DATA_W = 8).
3. Wait states: INSTR_VALID held low 3 cycles in FETCH -> PC and INSTR_REQ stable, no RETIRE, no register change. Instruction executes on the 4th cycle's edge.
4. Control flow at PC = 0x20:
   - beq off = 0xFE with equal operands -> next PC = 0x1C.
   - Unequal operands -> next PC = 0x24.
   - j off = 0x03 at PC = 0x40 -> next PC = 0x50; ALU_OUT unchanged.
5. Opcode 0x3A -> RETIRE and ILLEGAL_OP both pulse for one cycle, PC += 4, registers/ALU_OUT/ZERO unchanged.
6. Reset while in EXEC of add r1,r1,r1 -> r1 = 0, PC = 0, outputs at reset values.
7. DATA_W = 16, REG_CNT = 16: loadi r15,0xFF; add r15,r15,r15 repeated 9 times -> values wrap mod 2^16 (final 0xFE00). A subsequent add of r15 to itself with 0x8000 gives 0x0000 with ZERO = 1.

Source files
------------

// File: rtl/param_cpu_core.sv
// param_cpu_core
// Multi-cycle processor core with a parameterisable datapath, register
// file and program counter. It fetches 32-bit instructions over a
// request/valid handshake, so instruction memory may insert wait states.
// Each instruction then executes in a single EXEC cycle.
//
// Parameters:
//   DATA_W  - datapath and register width in bits (>= 8)
//   REG_CNT - number of general registers (power of two, 2..256)
//   PC_W    - program counter width in bits (> 8); arithmetic wraps
//
// Ports:
//   CLK         - clock, all state changes on the rising edge
//   RESET       - synchronous active-low reset
//   INSTR_REQ   - high while the core waits for an instruction word
//   PC          - byte address of the instruction being fetched/executed
//   INSTRUCTION - instruction word, taken when INSTR_REQ && INSTR_VALID
//   INSTR_VALID - instruction memory response valid
//   ALU_OUT     - registered result of the last ALU operation
//   ZERO        - registered flag, set when ALU_OUT is all zeros
//   RETIRE      - one-cycle pulse per completed instruction
//   ILLEGAL_OP  - one-cycle pulse alongside RETIRE for an undefined opcode
module param_cpu_core #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8,
  parameter int PC_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              INSTR_REQ,
  output logic [PC_W-1:0]   PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic              ZERO,
  output logic              RETIRE,
  output logic              ILLEGAL_OP
);

  localparam int IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  typedef enum logic [1:0] {RST, FETCH, EXEC} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [REG_CNT];

  logic [7:0]        opcode;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rs1_idx;
  logic [IDX_W-1:0]  rs2_idx;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] alu_res;
  logic              writes_rd;
  logic              updates_alu;
  logic              is_illegal;
  logic              take_jump;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   jump_target;
  logic [PC_W-1:0]   next_pc;
  logic              unused_ir_bits;

  // Field decode; register indices only use the low bits of each field.
  assign opcode  = ir[31:24];
  assign rd_idx  = ir[16 +: IDX_W];
  assign rs1_idx = ir[8 +: IDX_W];
  assign rs2_idx = ir[0 +: IDX_W];
  assign rs1_val = regs[rs1_idx];
  assign rs2_val = regs[rs2_idx];

  // The upper rs1 field bits are meaningless for small register files.
  assign unused_ir_bits = ^ir[15:8];

  // Branch offset counts instruction words, so scale it by four.
  assign off_ext     = {{(PC_W-8){ir[23]}}, ir[23:16]};
  assign pc_plus4    = PC + PC_W'(4);
  assign jump_target = pc_plus4 + (off_ext << 2);
  assign next_pc     = take_jump ? jump_target : pc_plus4;

  always_comb begin
    alu_res     = '0;
    writes_rd   = 1'b0;
    updates_alu = 1'b1;
    is_illegal  = 1'b0;
    take_jump   = 1'b0;
    case (opcode)
      8'h00: begin
        alu_res   = DATA_W'(ir[7:0]);
        writes_rd = 1'b1;
      end
      8'h01: begin
        alu_res   = rs2_val;
        writes_rd = 1'b1;
      end
      8'h02: begin
        alu_res   = rs1_val + rs2_val;
        writes_rd = 1'b1;
      end
      8'h03: begin
        alu_res   = rs1_val + ~rs2_val + DATA_W'(1);
        writes_rd = 1'b1;
      end
      8'h04: begin
        alu_res   = rs1_val & rs2_val;
        writes_rd = 1'b1;
      end
      8'h05: begin
        alu_res   = rs1_val | rs2_val;
        writes_rd = 1'b1;
      end
      8'h06: begin
        updates_alu = 1'b0;
        take_jump   = 1'b1;
      end
      8'h07: begin
        alu_res   = rs1_val + ~rs2_val + DATA_W'(1);
        take_jump = (rs1_val == rs2_val);
      end
      default: begin
        updates_alu = 1'b0;
        is_illegal  = 1'b1;
      end
    endcase
  end

  // Reset aborts whatever is in flight: nothing from a half-executed
  // instruction reaches the register file or the PC.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= RST;
      PC         <= '0;
      INSTR_REQ  <= 1'b0;
      ALU_OUT    <= '0;
      ZERO       <= 1'b1;
      RETIRE     <= 1'b0;
      ILLEGAL_OP <= 1'b0;
      ir         <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      RETIRE     <= 1'b0;
      ILLEGAL_OP <= 1'b0;
      case (state)
        RST: begin
          state     <= FETCH;
          INSTR_REQ <= 1'b1;
        end
        FETCH: begin
          if (INSTR_VALID) begin
            ir        <= INSTRUCTION;
            INSTR_REQ <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Operands were read before this edge, so rd == rs1/rs2 is safe.
          if (writes_rd) begin
            regs[rd_idx] <= alu_res;
          end
          if (updates_alu) begin
            ALU_OUT <= alu_res;
            ZERO    <= (alu_res == '0);
          end
          PC         <= next_pc;
          RETIRE     <= 1'b1;
          ILLEGAL_OP <= is_illegal;
          INSTR_REQ  <= 1'b1;
          state      <= FETCH;
        end
        default: begin
          state     <= RST;
          INSTR_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule
